dense_sequencer: RTL and testbench
==================================

DENSE_SEQUENCER -- requirements
Module: dense_sequencer

Interface
REQ-001 SHALL have parameters: BIT_DATA, default 8, activation width; KSIZE, default 10, output neurons; SIZE, default 128, input vector length; LATENCY, default 4, result pipeline depth in cycles, legal range 1..15; BIT_Z, default 16, score width; BIT_O, default 4, index width; BIT_W = BIT_DATA*KSIZE, weight-row width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high, ports named clock and reset.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 w_valid / w_ready  in / out  1 / 1  weight-row stream handshake.
REQ-006 w_data  in  BIT_W  one weight row, all KSIZE neurons.
REQ-007 x_valid / x_ready  in / out  1 / 1  activation stream handshake.
REQ-008 x_data  in  BIT_DATA  one signed activation.
REQ-009 start  in  1  inference request pulse.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 wgt_loaded  out  1  a complete weight set is resident.
REQ-012 dl_load, dl_run  out  1 each  datapath weight write strobe and accumulate enable.
REQ-013 dl_addr  out  clog2(SIZE)  row index for write or accumulate.
REQ-014 dl_w / dl_x  out  BIT_W / BIT_DATA  datapath weight and activation.
REQ-015 dl_z / dl_index  in  BIT_Z / BIT_O  datapath argmax score and index.
REQ-016 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-017 res_z / res_index  out  BIT_Z / BIT_O  registered result.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DRAIN, HOLD with a single row counter rc (0..SIZE-1) and a drain counter dc.
REQ-019 IDLE: start=1 with wgt_loaded=1 -> RUN; else w_valid=1 -> LOAD, clearing wgt_loaded; start with wgt_loaded=0 ignored; start wins if both start and w_valid are high.
REQ-020 LOAD: w_ready=1; each w_valid&w_ready cycle: dl_load=1, dl_addr=rc, dl_w=w_data (combinational), rc increments; on the SIZE-th transfer rc wraps to 0, wgt_loaded<=1, next state IDLE.
REQ-021 RUN: x_ready=1; each x_valid&x_ready cycle: dl_run=1, dl_x=x_data, dl_addr=rc, rc increments; x_valid=0 -> dl_run=0, rc held (stall, no bubble counted); on the SIZE-th transfer rc wraps to 0, dc<=LATENCY, next state DRAIN.
REQ-022 DRAIN: dl_run=0, dl_load=0, dc decrements each cycle; when dc reaches 1, capture dl_z/dl_index into res_z/res_index, set res_valid, next state HOLD; total DRAIN dwell = LATENCY cycles.
REQ-023 HOLD: res_valid=1, res_z/res_index stable; res_ready=1 -> res_valid<=0, next state IDLE in that edge.
REQ-024 Outside their states: w_ready=0, x_ready=0, dl_load=0, dl_run=0; dl_w, dl_x driven 0; dl_addr=rc.
REQ-025 dl_load and dl_run SHALL never be high in the same cycle.
REQ-026 start in any non-IDLE state SHALL be ignored; w_valid/x_valid outside LOAD/RUN SHALL be ignored (no transfer).
REQ-027 Minimum inference latency, start edge to res_valid: 1 + SIZE + LATENCY cycles with x_valid held high.

Reset
REQ-028 reset SHALL force IDLE, rc=0, dc=0, wgt_loaded=0, res_valid=0, res_z=0, res_index=0, all strobes and ready outputs 0, immediately and independent of clock.
REQ-029 reset mid-LOAD or mid-RUN SHALL abandon the operation; a fresh full weight load is required before the next start is accepted.

Verification
REQ-030 Load SIZE=128 rows, w_valid held -> dl_load high 128 cycles, dl_addr 0..127, wgt_loaded=1, state IDLE.
REQ-031 start with wgt_loaded=0 -> busy stays 0, no x_ready.
REQ-032 Full inference, x_valid always 1, LATENCY=4, dl_z=0x0123, dl_index=7 -> res_valid rises 133 cycles after start, res_z=0x0123, res_index=7.
REQ-033 RUN with x_valid low every other cycle -> exactly 128 dl_run pulses, dl_addr contiguous, DRAIN entered after 128th.
REQ-034 HOLD with res_ready=0 for 10 cycles -> res_valid and outputs stable; res_ready=1 -> IDLE next cycle, busy=0.
REQ-035 reset asserted at RUN row 50 -> all outputs 0 asynchronously, wgt_loaded=0, later start ignored until reload.

Source files
------------

// File: rtl/dense_sequencer.sv
// Control sequencer for a dense (fully connected) layer: streams weight rows into
// the datapath, streams activations through it, waits out its pipeline, holds the argmax.
module dense_sequencer #(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 10,
  parameter int SIZE     = 128,
  parameter int LATENCY  = 4,
  parameter int BIT_Z    = 16,
  parameter int BIT_O    = 4,
  parameter int BIT_W    = BIT_DATA * KSIZE,
  localparam int AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [BIT_W-1:0]    w_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [BIT_DATA-1:0] x_data,
  input  logic                start,
  output logic                busy,
  output logic                wgt_loaded,
  output logic                dl_load,
  output logic                dl_run,
  output logic [AW-1:0]       dl_addr,
  output logic [BIT_W-1:0]    dl_w,
  output logic [BIT_DATA-1:0] dl_x,
  input  logic [BIT_Z-1:0]    dl_z,
  input  logic [BIT_O-1:0]    dl_index,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BIT_Z-1:0]    res_z,
  output logic [BIT_O-1:0]    res_index
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rc_q, rc_d;
  logic [3:0]       dc_q, dc_d;
  logic             wgt_loaded_q, wgt_loaded_d;
  logic             res_valid_q, res_valid_d;
  logic [BIT_Z-1:0] res_z_q, res_z_d;
  logic [BIT_O-1:0] res_index_q, res_index_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rc_q         <= '0;
      dc_q         <= '0;
      wgt_loaded_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_z_q      <= '0;
      res_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      dc_q         <= dc_d;
      wgt_loaded_q <= wgt_loaded_d;
      res_valid_q  <= res_valid_d;
      res_z_q      <= res_z_d;
      res_index_q  <= res_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    dc_d         = dc_q;
    wgt_loaded_d = wgt_loaded_q;
    res_valid_d  = res_valid_q;
    res_z_d      = res_z_q;
    res_index_d  = res_index_q;
    w_ready      = 1'b0;
    x_ready      = 1'b0;
    dl_load      = 1'b0;
    dl_run       = 1'b0;
    dl_w         = '0;
    dl_x         = '0;
    case (state_q)
      IDLE: begin
        if (start && wgt_loaded_q) begin
          state_d = RUN;
        end else if (w_valid) begin
          // Any partial reload invalidates the resident set until it completes.
          state_d      = LOAD;
          wgt_loaded_d = 1'b0;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          dl_load = 1'b1;
          dl_w    = w_data;
          if (rc_q == AW'(SIZE - 1)) begin
            rc_d         = '0;
            wgt_loaded_d = 1'b1;
            state_d      = IDLE;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      RUN: begin
        x_ready = 1'b1;
        if (x_valid) begin
          dl_run = 1'b1;
          dl_x   = x_data;
          if (rc_q == AW'(SIZE - 1)) begin
            rc_d    = '0;
            dc_d    = 4'(LATENCY);
            state_d = DRAIN;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        dc_d = dc_q - 1'b1;
        // Last drain cycle: the datapath argmax is final, so capture it.
        if (dc_q <= 4'd1) begin
          dc_d        = '0;
          res_z_d     = dl_z;
          res_index_d = dl_index;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign wgt_loaded = wgt_loaded_q;
  assign dl_addr    = rc_q;
  assign res_valid  = res_valid_q;
  assign res_z      = res_z_q;
  assign res_index  = res_index_q;

endmodule

// File: tb/tb_dense_sequencer.sv
// Scoreboard bench for dense_sequencer: stimulus pushes expected datapath strobes and
// results into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_dense_sequencer;
  localparam int SIZE  = 128;
  localparam int BIT_W = 80;
  localparam int AW    = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             w_valid = 1'b0, w_ready;
  logic [BIT_W-1:0] w_data = '0;
  logic             x_valid = 1'b0, x_ready;
  logic [7:0]       x_data = '0;
  logic             start = 1'b0, busy, wgt_loaded, dl_load, dl_run;
  logic [AW-1:0]    dl_addr;
  logic [BIT_W-1:0] dl_w;
  logic [7:0]       dl_x;
  logic [15:0]      dl_z = '0;
  logic [3:0]       dl_index = '0;
  logic             res_valid, res_ready = 1'b1;
  logic [15:0]      res_z;
  logic [3:0]       res_index;

  int n_vec = 0;
  int n_err = 0;

  logic [AW+BIT_W-1:0] ld_q[$];
  logic [AW+7:0]       run_q[$];
  logic [19:0]         res_q[$];

  always #5 clock = ~clock;

  dense_sequencer dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .start(start), .busy(busy), .wgt_loaded(wgt_loaded),
    .dl_load(dl_load), .dl_run(dl_run), .dl_addr(dl_addr),
    .dl_w(dl_w), .dl_x(dl_x), .dl_z(dl_z), .dl_index(dl_index),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_index(res_index)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BIT_W-1:0] wrow(input int k);
    logic [7:0] b;
    b = 8'(k * 3 + 1);
    return {10{b}} ^ {16'(k), 64'h0F1E_2D3C_4B5A_6978};
  endfunction

  function automatic logic [7:0] xrow(input int k);
    return 8'(k * 7 + 5);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every strobe and result the DUT presents must match the head of its queue.
  always @(negedge clock) begin : monitor
    logic [AW+BIT_W-1:0] e_ld;
    logic [AW+7:0]       e_run;
    logic [19:0]         e_res;
    if (!reset) begin
      if (dl_load && dl_run) check("strobe_overlap", 1, 0);
      if (dl_load) begin
        if (ld_q.size() == 0) check("unexpected_load", 1, 0);
        else begin
          e_ld = ld_q.pop_front();
          check("load_xfer", {dl_addr, dl_w}, e_ld);
        end
      end
      if (dl_run) begin
        if (run_q.size() == 0) check("unexpected_run", 1, 0);
        else begin
          e_run = run_q.pop_front();
          check("run_xfer", {dl_addr, dl_x}, e_run);
        end
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          e_res = res_q.pop_front();
          check("result", {res_z, res_index}, e_res);
          $display("result z=%04h index=%0d", res_z, res_index);
        end
      end
    end
  end

  task automatic load_all;
    int  k = 0;
    int  guard = 0;
    bit  xfer;
    while (k < SIZE && guard < 1000) begin
      w_valid = 1'b1;
      w_data  = wrow(k);
      xfer    = w_ready;
      if (xfer) ld_q.push_back({AW'(k), wrow(k)});
      tick;
      guard++;
      if (xfer) k++;
    end
    w_valid = 1'b0;
    w_data  = '0;
    check("load_count", k, SIZE);
    check("load_wgt_loaded", wgt_loaded, 1);
    check("load_idle", busy, 0);
  endtask

  // Runs one inference; stops early after stop_at transfers (0 = run to result).
  task automatic infer(input bit gappy, input logic [15:0] z, input logic [3:0] idx,
                       input int stop_at, output int cyc);
    int k = 0;
    bit ph = 1'b0;
    bit xfer;
    dl_z     = z;
    dl_index = idx;
    if (stop_at == 0) res_q.push_back({z, idx});
    start = 1'b1;
    cyc   = 0;
    while (!res_valid && cyc < 600 && !(stop_at != 0 && k == stop_at)) begin
      x_valid = (k < SIZE) && (!gappy || ph);
      ph      = ~ph;
      x_data  = xrow(k);
      xfer    = x_valid && x_ready;
      if (xfer) run_q.push_back({AW'(k), xrow(k)});
      tick;
      start = 1'b0;
      cyc++;
      if (xfer) k++;
      if (xfer && k == SIZE) begin
        check("drain_entry_xready", x_ready, 0);
        check("drain_entry_busy", busy, 1);
      end
    end
    x_valid = 1'b0;
    if (stop_at == 0) check("result_seen", res_valid, 1);
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_wgt_loaded", wgt_loaded, 0);
    check("rst_res", {res_valid, res_z, res_index}, 0);
    check("rst_strobes", {w_ready, x_ready, dl_load, dl_run}, 0);
    check("rst_addr", dl_addr, 0);
    tick; tick;
    reset = 1'b0;
    tick;

    // start without weights is ignored
    start = 1'b1;
    tick;
    start = 1'b0;
    check("nowgt_busy", busy, 0);
    check("nowgt_xready", x_ready, 0);
    tick;
    check("nowgt_busy2", busy, 0);

    load_all();

    // full-rate inference with a held result
    res_ready = 1'b0;
    infer(1'b0, 16'h0123, 4'd7, 0, cyc);
    check("latency", cyc, 133);
    for (int i = 0; i < 10; i++) begin
      dl_z     = 16'hFFFF;
      dl_index = 4'd0;
      check("hold_valid", res_valid, 1);
      check("hold_data", {res_z, res_index}, {16'h0123, 4'd7});
      check("hold_busy", busy, 1);
      tick;
    end
    res_ready = 1'b1;
    tick;
    check("release_busy", busy, 0);
    check("release_valid", res_valid, 0);

    // stalled inference, x_valid every other cycle
    infer(1'b1, 16'hBEEF, 4'd3, 0, cyc);
    tick;
    check("gappy_idle", busy, 0);

    // reset at RUN row 50
    infer(1'b0, 16'h0000, 4'd0, 50, cyc);
    check("run50_busy", busy, 1);
    check("run50_addr", dl_addr, 50);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_outs", {x_ready, dl_run, dl_load, w_ready, res_valid}, 0);
    check("async_rst_addr", dl_addr, 0);
    check("async_rst_wgt", wgt_loaded, 0);
    tick;
    reset = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("post_rst_start_ignored", busy, 0);
    tick;
    check("post_rst_xready", x_ready, 0);

    // reload, then an inference works again
    load_all();
    infer(1'b0, 16'h5A5A, 4'd9, 0, cyc);
    check("reload_latency", cyc, 133);
    tick;
    check("reload_idle", busy, 0);

    check("ld_q_drained", ld_q.size(), 0);
    check("run_q_drained", run_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
